// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-add 8x8 unsigned multiplier driving an external combinational ALU.
// Optional MUL_ZERO_SKIP_EN: zero operands finish immediately without running the iterations.
module alu_mul_sequencer #(
  parameter logic [1:0] OP_ADD = 2'b00,
  parameter int N_ITER = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        product_zero,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_co
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] acc_hi, acc_lo, m;
  logic [2:0] cnt;
  logic [15:0] shifted;
  logic accept, last, zero_op;
`ifdef MUL_ZERO_SKIP_EN
  assign zero_op = multiplicand == 8'd0 || multiplier == 8'd0;
`else
  assign zero_op = 1'b0;
`endif
  assign ready   = state == IDLE;
  assign busy    = state == RUN;
  assign done    = state == DONE;
  assign accept  = start && ready;
  assign last    = cnt == 3'(N_ITER - 1);
  // ALU carry becomes the new product MSB; the multiplier LSB falls off the bottom.
  assign shifted = {alu_co, alu_out, acc_lo[7:1]};
  assign product = {acc_hi, acc_lo};
  assign alu_a   = busy ? acc_hi : 8'd0;
  assign alu_b   = busy && acc_lo[0] ? m : 8'd0;
  assign alu_sel = OP_ADD;
  always_comb begin
    state_nx = state;
    state_nx = ready ? (accept ? (zero_op ? DONE : RUN) : IDLE) : busy ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= 8'd0;
      acc_lo <= 8'd0;
      m <= 8'd0;
      cnt <= 3'd0;
      product_zero <= 1'b0;
    end else if (accept) begin
      acc_hi <= 8'd0;
      acc_lo <= zero_op ? 8'd0 : multiplier;
      m <= multiplicand;
      cnt <= 3'd0;
      product_zero <= zero_op ? 1'b1 : product_zero;
    end else if (busy) begin
      {acc_hi, acc_lo} <= shifted;
      cnt <= cnt + 3'd1;
      product_zero <= last ? shifted == 16'd0 : product_zero;
    end
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: scoreboard bench; expected products come from plain M*Q arithmetic.
module tb_alu_mul_sequencer;
  logic clk = 0, rst_n = 0, start = 0;
  logic [7:0] multiplicand = 0, multiplier = 0;
  logic ready, busy, done, product_zero, alu_co;
  logic [15:0] product;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [1:0] alu_sel;
  int errors = 0, checks = 0, cyc = 0, co_seen = 0;
  logic prev_done = 0;
  typedef struct { logic [15:0] p; logic z; int due; logic [7:0] a, b; } exp_t;
  exp_t sb[$];

  alu_mul_sequencer dut (.clk(clk), .rst_n(rst_n), .start(start), .multiplicand(multiplicand),
    .multiplier(multiplier), .ready(ready), .busy(busy), .done(done), .product(product),
    .product_zero(product_zero), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_co(alu_co));

  // the shared combinational ALU performing ADD
  assign {alu_co, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic cycle(input logic st, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int lat;
    @(negedge clk);
    start = st; multiplicand = a; multiplier = b;
    #1;
    if (st && ready && rst_n) begin
      e.p = 16'(a) * 16'(b);
      e.z = e.p == 16'd0;
      lat = 9;
`ifdef MUL_ZERO_SKIP_EN
      if (a == 0 || b == 0) lat = 1;
`endif
      e.due = cyc + lat;
      e.a = a; e.b = b;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    cycle(1, a, b);
    repeat (10) cycle(0, 0, 0);
  endtask

  always @(negedge clk) if (rst_n) begin
    exp_t e;
    checks++;
    if (alu_sel !== 2'b00 || (!busy && (alu_a !== 8'd0 || alu_b !== 8'd0))) begin
      errors++;
      $display("FAIL alu_quiet: sel=%b a=%h b=%h busy=%b", alu_sel, alu_a, alu_b, busy);
    end
    if (prev_done) chk("ready_after_done", 16'(ready), 16'd1);
    prev_done = done;
    if (busy && alu_co) co_seen++;
    if (done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done: got done=1 expected no pending op (product=%h)", product);
      end else begin
        e = sb.pop_front();
        chk($sformatf("product %0d*%0d", e.a, e.b), product, e.p);
        chk($sformatf("product_zero %0d*%0d", e.a, e.b), 16'(product_zero), 16'(e.z));
        chk($sformatf("latency %0d*%0d", e.a, e.b), 16'(cyc), 16'(e.due));
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done by cycle %0d expected at %0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  initial begin
    int co0;
    logic [7:0] a, b;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 16'(ready), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_product", product, 16'd0);
    chk("rst_pz", 16'(product_zero), 16'd0);
    @(negedge clk); #1 rst_n = 1;
    run_op(13, 11);
    co0 = co_seen;
    run_op(255, 255);
    chk("carry_seen", 16'(co_seen > co0), 16'd1);
    run_op(0, 8'h5A);
    run_op(8'h5A, 0);
    // restart attempt during RUN at E3 must be ignored
    cycle(1, 7, 9);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 2, 2);
    repeat (10) cycle(0, 0, 0);
    // asynchronous reset mid-RUN after E4
    cycle(1, 100, 200);
    repeat (4) cycle(0, 0, 0);
    #2 rst_n = 0;
    #1;
    sb.delete();
    chk("midrst_ready", 16'(ready), 16'd1);
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_product", product, 16'd0);
    @(negedge clk); #1 rst_n = 1;
    prev_done = 0;
    repeat (3) cycle(0, 0, 0);
    run_op(100, 200);
    for (int i = 0; i < 20; i++) begin
      a = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      run_op(a, b);
    end
    // start held high with changing operands
    for (int i = 0; i < 60; i++) cycle(1, 8'($urandom), 8'($urandom));
    repeat (12) cycle(0, 0, 0);
    chk("drained", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
